muskbus_mem_responder: RTL and testbench

- Top-side (responder) endpoint of the Muskbus; the counterpart of a cache/initiator driving the Bottom side.
- Accepts 64-byte line read and write requests, backs them with an internal word-addressed memory, and returns read data as 8 beats after a programmable latency.
- Used as a standalone memory model for bus-level integration and as the starting point for the MMIO/port responders.

---
 rtl/muskbus_mem_responder_pkg.sv | 27 ++
 rtl/muskbus_line_mem.sv | 26 ++
 rtl/muskbus_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_muskbus_mem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muskbus_mem_responder_pkg.sv
// Shared Muskbus constants: request-tag field layout, type codes and the
// responder state encoding.
`timescale 1ns/1ps
package muskbus_mem_responder_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [3:0] TYPE_MEMORY = 4'b0001;
    localparam logic [3:0] TYPE_MMIO   = 4'b0010;
    localparam logic [3:0] TYPE_PORT   = 4'b0011;
    localparam logic [3:0] TYPE_IRQ    = 4'b0100;

    localparam int TAG_RW_BIT   = 12;
    localparam int TAG_TYPE_MSB = 11;
    localparam int TAG_TYPE_LSB = 8;
    localparam int TAG_ID_MSB   = 7;
    localparam int TAG_ID_LSB   = 0;

    // Plain encoded constants keep the state register readable by older tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WR_DATA = 2'd1;
    localparam state_t ST_RD_WAIT = 2'd2;
    localparam state_t ST_RD_DATA = 2'd3;

endpackage

// File: rtl/muskbus_line_mem.sv
// Line storage: synchronous write, combinational read, word index {line, beat}.
`timescale 1ns/1ps
module muskbus_line_mem #(
    parameter int MEM_LINES = 256,
    parameter int BEATS     = 8,
    parameter int ADDR_W    = $clog2(MEM_LINES * BEATS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [63:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [63:0]       rdata_o
);

    logic [63:0] mem_q [MEM_LINES*BEATS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/muskbus_mem_responder.sv
// Muskbus top-side responder backed by an internal line memory; serves 64-byte
// line writes and returns line reads as 8 beats after a fixed latency.
`timescale 1ns/1ps
module muskbus_mem_responder
    import muskbus_mem_responder_pkg::*;
#(
    parameter int READ_LATENCY = 4,
    parameter int MEM_LINES    = 256,
    parameter int BEATS        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bid,
    input  logic [63:0] req,
    input  logic [12:0] reqtag,
    input  logic        reqcyc,
    output logic        reqack,
    output logic [63:0] resp,
    output logic        respcyc,
    input  logic        respack,
    output logic        busy,
    output logic        err_unsupported,
    output logic        last_bid
);

    localparam int LINE_W = $clog2(MEM_LINES);
    localparam int ADDR_W = LINE_W + 3;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

    state_t             state_q, state_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [7:0]         tag_q, tag_d;
    logic               bid_q, bid_d;
    logic [2:0]         beat_q, beat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [63:0]        resp_q, resp_d;
    logic               respcyc_q, respcyc_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               req_rw;
    logic [3:0]         req_type;
    logic [2:0]         beat_nxt;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [ADDR_W-1:0]  mem_raddr;
    logic [63:0]        mem_rdata;
    logic               unused_tag;

    assign reqack   = reqcyc && (state_q == ST_IDLE || state_q == ST_WR_DATA);
    assign xfer     = reqcyc && reqack;
    assign req_rw   = reqtag[TAG_RW_BIT];
    assign req_type = reqtag[TAG_TYPE_MSB:TAG_TYPE_LSB];
    assign beat_nxt = beat_q + 3'd1;

    // Read port looks one beat ahead so the next beat is ready when respack lands.
    assign mem_we    = (state_q == ST_WR_DATA) && xfer;
    assign mem_waddr = {line_q, beat_q};
    assign mem_raddr = (state_q == ST_RD_DATA) ? {line_q, beat_nxt} : {line_q, 3'd0};

    muskbus_line_mem #(
        .MEM_LINES (MEM_LINES),
        .BEATS     (BEATS),
        .ADDR_W    (ADDR_W)
    ) u_line_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (req),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        tag_d     = tag_q;
        bid_d     = bid_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        resp_d    = resp_q;
        respcyc_d = respcyc_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    line_d = req[6 +: LINE_W];
                    tag_d  = reqtag[TAG_ID_MSB:TAG_ID_LSB];
                    bid_d  = bid;
                    if (req_type != TYPE_MEMORY) begin
                        err_d = 1'b1;
                    end else if (req_rw == RW_READ) begin
                        lat_d   = LAT_INIT;
                        state_d = ST_RD_WAIT;
                    end else begin
                        beat_d  = 3'd0;
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
                if (xfer) begin
                    beat_d = beat_nxt;
                    if (beat_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (lat_q == '0) begin
                    resp_d    = mem_rdata;
                    respcyc_d = 1'b1;
                    beat_d    = 3'd0;
                    state_d   = ST_RD_DATA;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RD_DATA: begin
                if (respack && respcyc_q) begin
                    if (beat_q == 3'd7) begin
                        respcyc_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_d = beat_nxt;
                        resp_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            tag_q     <= '0;
            bid_q     <= 1'b0;
            beat_q    <= 3'd0;
            lat_q     <= '0;
            resp_q    <= '0;
            respcyc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            bid_q     <= bid_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            resp_q    <= resp_d;
            respcyc_q <= respcyc_d;
            err_q     <= err_d;
        end
    end

    assign resp            = resp_q;
    assign respcyc         = respcyc_q;
    assign busy            = (state_q != ST_IDLE);
    assign err_unsupported = err_q;
    assign last_bid        = bid_q;

    // The request tag is captured for future responders that echo it back.
    assign unused_tag = ^tag_q;

endmodule

// File: tb/tb_muskbus_mem_responder.sv
// Directed scoreboard bench for muskbus_mem_responder: writes, reads,
// backpressure, address wrap, unsupported types, queued requests and reset abort.
`timescale 1ns/1ps
module tb_muskbus_mem_responder;
    import muskbus_mem_responder_pkg::*;

    localparam int READ_LATENCY = 4;
    localparam int MEM_LINES    = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bid = 1'b0;
    logic [63:0] req = '0;
    logic [12:0] reqtag = '0;
    logic        reqcyc = 1'b0;
    logic        respack = 1'b0;
    logic        reqack;
    logic [63:0] resp;
    logic        respcyc;
    logic        busy;
    logic        err_unsupported;
    logic        last_bid;

    int vecCount  = 0;
    int missCount = 0;

    logic [63:0] modelMem [MEM_LINES][8];
    logic [63:0] expQ [$];

    muskbus_mem_responder #(
        .READ_LATENCY (READ_LATENCY),
        .MEM_LINES    (MEM_LINES),
        .BEATS        (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bid             (bid),
        .req             (req),
        .reqtag          (reqtag),
        .reqcyc          (reqcyc),
        .reqack          (reqack),
        .resp            (resp),
        .respcyc         (respcyc),
        .respack         (respack),
        .busy            (busy),
        .err_unsupported (err_unsupported),
        .last_bid        (last_bid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        vecCount++;
        assert (got === want) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic [63:0] data, input logic [12:0] tagVal);
        reqcyc = cyc;
        req    = data;
        reqtag = tagVal;
    endtask

    function automatic int lineOf(input logic [63:0] addr);
        return int'((addr >> 6) % MEM_LINES);
    endfunction

    task automatic writeLine(input logic [63:0] addr, input logic [63:0] seed,
                             input int bubbleAt, input int bubbleLen, input logic bidVal);
        int line;
        logic [63:0] data;
        line = lineOf(addr);
        bid = bidVal;
        applyStimulus(1'b1, addr, {RW_WRITE, TYPE_MEMORY, 8'h10});
        #1 checkOutput("wr_req_ack", reqack, 1);
        @(posedge clk); #1;
        for (int b = 0; b < 8; b++) begin
            if (b == bubbleAt) begin
                for (int k = 0; k < bubbleLen; k++) begin
                    reqcyc = 1'b0;
                    #1 checkOutput("wr_bubble_noack", reqack, 0);
                    @(posedge clk); #1;
                end
            end
            data = seed + 64'(b) * 64'h11;
            modelMem[line][b] = data;
            applyStimulus(1'b1, data, {RW_WRITE, TYPE_MEMORY, 8'h10});
            #1 checkOutput("wr_beat_ack", reqack, 1);
            @(posedge clk); #1;
        end
        reqcyc = 1'b0;
        #1 checkOutput("wr_done_idle", busy, 0);
        checkOutput("wr_last_bid", last_bid, bidVal);
    endtask

    // ackMode 0 holds respack high; 1 toggles 1,0,0,1,0,0...
    // abortAfter >= 0 pulls reset once that many beats have been consumed.
    task automatic readLine(input logic [63:0] addr, input int ackMode, input logic bidVal,
                            input int abortAfter, input logic pend, input logic [63:0] pendAddr);
        int line;
        int beats;
        int guard;
        bit aborted;
        line = lineOf(addr);
        expQ.delete();
        for (int b = 0; b < 8; b++) expQ.push_back(modelMem[line][b]);
        bid = bidVal;
        applyStimulus(1'b1, addr, {RW_READ, TYPE_MEMORY, 8'h20});
        #1 checkOutput("rd_req_ack", reqack, 1);
        @(posedge clk); #1;
        if (pend) applyStimulus(1'b1, pendAddr, {RW_WRITE, TYPE_MEMORY, 8'h30});
        else reqcyc = 1'b0;
        checkOutput("rd_last_bid", last_bid, bidVal);
        for (int n = 1; n <= READ_LATENCY; n++) begin
            #1 checkOutput("rd_latency_low", respcyc, 0);
            if (pend) checkOutput("rd_wait_noack", reqack, 0);
            @(posedge clk); #1;
        end
        beats = 0;
        guard = 0;
        aborted = 0;
        while (beats < 8 && guard < 100) begin
            if (abortAfter >= 0 && beats == abortAfter) begin
                reset_n = 1'b0;
                #1 checkOutput("rst_async_respcyc", respcyc, 0);
                expQ.delete();
                aborted = 1;
                break;
            end
            respack = (ackMode == 0) ? 1'b1 : ((guard % 3) == 0);
            #1;
            if (guard == 0) checkOutput("rd_first_beat_time", respcyc, 1);
            if (pend) checkOutput("rd_data_noack", reqack, 0);
            if (respcyc) begin
                checkOutput("rd_beat_data", resp, expQ[0]);
                if (respack) begin
                    void'(expQ.pop_front());
                    beats++;
                end
            end else begin
                checkOutput("rd_respcyc_drop", respcyc, 1);
            end
            @(posedge clk); #1;
            guard++;
        end
        respack = 1'b0;
        if (!aborted) begin
            checkOutput("rd_timeout_beats", 64'(beats), 64'd8);
            #1 checkOutput("rd_end_respcyc", respcyc, 0);
            checkOutput("rd_end_busy", busy, 0);
            if (pend) checkOutput("pend_accept", reqack, 1);
        end
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_respcyc", respcyc, 0);
        checkOutput("rst_resp", resp, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err_unsupported, 0);
        checkOutput("rst_last_bid", last_bid, 0);
        checkOutput("rst_reqack", reqack, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Write then read a line, respack held high.
        writeLine(64'h1000, 64'h11, -1, 0, 1'b1);
        readLine(64'h1000, 0, 1'b0, -1, 1'b0, 64'h0);

        // Response backpressure.
        writeLine(64'h2040, 64'hA5A5_0000_0000_0100, -1, 0, 1'b0);
        readLine(64'h2040, 1, 1'b1, -1, 1'b0, 64'h0);

        // Write bubbles before beat 4, then read through the wrapped alias.
        writeLine(64'h3FC0, 64'hDEAD_BEEF_0000_0011, 4, 2, 1'b1);
        readLine(64'h7FC0, 0, 1'b0, -1, 1'b0, 64'h0);

        // Unsupported type is acked once, flags the error, and sends nothing.
        bid = 1'b1;
        applyStimulus(1'b1, 64'h2000, {RW_READ, TYPE_MMIO, 8'h05});
        #1 checkOutput("unsup_ack", reqack, 1);
        @(posedge clk); #1;
        reqcyc = 1'b0;
        checkOutput("unsup_err", err_unsupported, 1);
        checkOutput("unsup_idle", busy, 0);
        checkOutput("unsup_last_bid", last_bid, 1);
        for (int i = 0; i < 6; i++) begin
            #1 checkOutput("unsup_no_resp", respcyc, 0);
            @(posedge clk); #1;
        end
        checkOutput("unsup_err_sticky", err_unsupported, 1);

        // Write presented during a read waits, then lands right after it.
        readLine(64'h1000, 1, 1'b0, -1, 1'b1, 64'h2040);
        writeLine(64'h2040, 64'h7700_0000_0000_0001, -1, 0, 1'b1);
        readLine(64'h2040, 0, 1'b0, -1, 1'b0, 64'h0);

        // Reset in the middle of a read burst.
        readLine(64'h3FC0, 0, 1'b1, 3, 1'b0, 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_respcyc", respcyc, 0);
        checkOutput("post_rst_err", err_unsupported, 0);
        @(posedge clk); #1;
        readLine(64'h3FC0, 1, 1'b0, -1, 1'b0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
